pipe_csel_addsub: RTL and testbench

PIPE_CSEL_ADDSUB -- requirements
Module: pipe_csel_addsub

---
 rtl/cseladd_pkg.sv | 26 ++
 rtl/csel_block.sv | 31 +++
 rtl/pipe_csel_addsub.sv | 105 ++++++++++
 tb/tb_pipe_csel_addsub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cseladd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cseladd_pkg
// Brief    : Shared constants, stage-count helper and stage record for the
//            pipelined carry-select adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package cseladd_pkg;

  localparam int unsigned DEF_N = 32;
  localparam int unsigned DEF_B = 8;

  function automatic int unsigned calc_stages(input int unsigned n, input int unsigned b);
    return n / b;
  endfunction

  localparam int unsigned DEF_L = calc_stages(DEF_N, DEF_B);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [DEF_N-1:0] psum;
  } stage_rec_t;

endpackage
`default_nettype wire

// File: rtl/csel_block.sv
`default_nettype none
// ============================================================================
// Module   : csel_block
// Brief    : Combinational B-bit carry-select block (both carry-in cases
//            precomputed, incoming carry picks one).
// Revision : 1.0 - initial release
// ============================================================================
module csel_block #(
  parameter int unsigned B = 8
) (
  input  logic [B-1:0] a_i,
  input  logic [B-1:0] b_i,
  input  logic         cin_i,
  output logic [B-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic [B:0] w_sum0;
  logic [B:0] w_sum1;

  assign w_sum0 = {1'b0, a_i} + {1'b0, b_i};
  assign w_sum1 = {1'b0, a_i} + {1'b0, b_i} + {{B{1'b0}}, 1'b1};

  assign {cout_o, sum_o} = cin_i ? w_sum1 : w_sum0;

  // Carry into the MSB recovered from the MSB half-sum identity.
  assign cmsb_o = sum_o[B-1] ^ a_i[B-1] ^ b_i[B-1];

endmodule
`default_nettype wire

// File: rtl/pipe_csel_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipe_csel_addsub
// Brief    : N-bit add/subtract pipelined as N/B carry-select stages with a
//            global-stall valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_csel_addsub
  import cseladd_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned B = DEF_B
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned L = calc_stages(N, B);

  if ((N % B) != 0) begin : g_width_check
    $error("pipe_csel_addsub: N must be a multiple of B");
  end

  typedef struct packed {
    logic         valid;
    logic         carry;
    logic         cmsb;
    logic [N-1:0] psum;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
  } stage_t;

  stage_t stage_q [L];
  stage_t stage_d [L];
  stage_t w_src   [L];

  logic [L-1:0][B-1:0] w_blk_sum;
  logic [L-1:0]        w_blk_cout;
  logic [L-1:0]        w_blk_cmsb;
  logic                w_adv;

  assign w_adv    = out_ready || !out_valid;
  assign in_ready = w_adv;

  // Stage 0 takes the live operands; subtraction becomes a + ~b + 1.
  always_comb begin
    w_src[0].valid = in_valid;
    w_src[0].carry = sub ? 1'b1 : cin;
    w_src[0].cmsb  = 1'b0;
    w_src[0].psum  = '0;
    w_src[0].opa   = a;
    w_src[0].opb   = sub ? ~b : b;
    for (int k = 1; k < int'(L); k++) begin
      w_src[k] = stage_q[k-1];
    end
  end

  for (genvar k = 0; k < int'(L); k++) begin : g_stage
    csel_block #(.B(B)) u_blk (
      .a_i    (w_src[k].opa[k*B +: B]),
      .b_i    (w_src[k].opb[k*B +: B]),
      .cin_i  (w_src[k].carry),
      .sum_o  (w_blk_sum[k]),
      .cout_o (w_blk_cout[k]),
      .cmsb_o (w_blk_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < int'(L); k++) begin
      stage_d[k]              = w_src[k];
      stage_d[k].psum[k*B +: B] = w_blk_sum[k];
      stage_d[k].carry        = w_blk_cout[k];
      stage_d[k].cmsb         = w_blk_cmsb[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(L); k++) begin
      if (rst) begin
        stage_q[k] <= '0;
      end else if (w_adv) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[L-1].valid;
  assign sum       = stage_q[L-1].psum;
  assign cout      = stage_q[L-1].carry;
  assign ovf       = stage_q[L-1].carry ^ stage_q[L-1].cmsb;

endmodule
`default_nettype wire

// File: tb/tb_pipe_csel_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_csel_addsub
// Brief    : Directed self-checking bench for pipe_csel_addsub (N=32, B=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_csel_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          n_pop    = 0;
  logic [33:0] sb_q [$];

  pipe_csel_addsub #(.N(32), .B(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result as {ovf, cout, sum}; overflow from the operand-sign rule.
  function automatic logic [33:0] model(input logic [31:0] fa, input logic [31:0] fb,
                                        input logic fc, input logic fs);
    logic [31:0] bb;
    logic [32:0] t;
    logic        o;
    bb = fs ? ~fb : fb;
    t  = {1'b0, fa} + {1'b0, bb} + {32'b0, (fs ? 1'b1 : fc)};
    o  = (fa[31] == bb[31]) && (t[31] != fa[31]);
    return {o, t[32], t[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_sample();
    logic [33:0] e;
    if (in_valid && in_ready) begin
      sb_q.push_back(model(a, b, cin, sub));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        n_pop++;
        check("result", {30'b0, ovf, cout, sum}, {30'b0, e});
      end
    end
  endtask

  task automatic run_single(input string tag, input logic [31:0] fa, input logic [31:0] fb,
                            input logic fc, input logic fs, input logic [31:0] es,
                            input logic ec, input logic eo);
    in_valid = 1'b1; a = fa; b = fb; cin = fc; sub = fs; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, "_early"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"},   sum,  es);
    check({tag, "_cout"},  cout, ec);
    check({tag, "_ovf"},   ovf,  eo);
    tick();
    check({tag, "_single"}, out_valid, 0);
  endtask

  initial begin
    bit stale;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);

    run_single("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_single("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_single("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_single("add_blk",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_single("add_cin",  32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0);
    run_single("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_single("sub_pos",  32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

    // Back-to-back burst: results on consecutive cycles 4..13.
    for (int c = 0; c < 16; c++) begin
      in_valid  = (c < 10);
      a         = 32'h0F0F_0000 + 32'(c) * 32'h1111_1111;
      b         = 32'hFFFF_FFF0 - 32'(c) * 32'h0100_0001;
      cin       = c[0];
      sub       = ((c % 3) == 2);
      out_ready = 1'b1;
      #1;
      check("burst_in_ready", in_ready, 1);
      check("burst_out_valid", out_valid, 64'((c >= 4) && (c < 14)));
      sb_sample();
      tick();
    end
    check("burst_drained", 64'(sb_q.size()), 0);

    // Full pipeline held off for six cycles, then drained.
    n_acc = 0;
    n_pop = 0;
    for (int c = 0; c < 40; c++) begin
      bit stalled;
      stalled   = (c >= 4) && (c < 10);
      in_valid  = (n_acc < 8);
      a         = 32'hA000_0000 + 32'(n_acc) * 32'h0123_4567;
      b         = 32'h6000_0000 + 32'(n_acc) * 32'h0F0F_0F0F;
      cin       = 1'b1;
      sub       = n_acc[0];
      out_ready = !stalled;
      #1;
      if (stalled) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        if (sb_q.size() > 0) begin
          check("stall_hold", {30'b0, ovf, cout, sum}, {30'b0, sb_q[0]});
        end
      end
      sb_sample();
      tick();
      if (n_acc == 8 && sb_q.size() == 0) break;
    end
    check("stall_accepted", 64'(n_acc), 8);
    check("stall_popped", 64'(n_pop), 8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_no_dup", out_valid, 0);

    // Reset with three beats in flight; a beat offered during reset is dropped.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a = 32'h0000_1000 + 32'(c);
      b = 32'h0000_0010;
      cin = 1'b0;
      sub = 1'b0;
      tick();
    end
    rst = 1'b1;
    in_valid = 1'b1;
    a = 32'hDEAD_BEEF;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    stale = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    check("midrst_no_stale", stale, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
